// File: rtl/cbus_ram_responder_pkg.sv
// Shared cbus protocol types used by the caches and the RAM responder.
package cbus_ram_responder_pkg;

   typedef logic [2:0] msize_t;
   localparam msize_t MSIZE1 = 3'd0;
   localparam msize_t MSIZE2 = 3'd1;
   localparam msize_t MSIZE4 = 3'd2;

   // Burst length encoded as beats-1.
   typedef logic [3:0] mlen_t;
   localparam mlen_t MLEN1  = 4'd0;
   localparam mlen_t MLEN2  = 4'd1;
   localparam mlen_t MLEN4  = 4'd3;
   localparam mlen_t MLEN8  = 4'd7;
   localparam mlen_t MLEN16 = 4'd15;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      msize_t      size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      mlen_t       len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} cbus_state_e;

endpackage

// File: rtl/cbus_ram_responder_stall_lfsr.sv
// Pseudo-random stall source: 16-bit Fibonacci LFSR (taps 16,14,13,11),
// stalls roughly one cycle in four.
module cbus_stall_lfsr (
   input  logic clk,
   input  logic resetn,
   output logic stall
);
   logic [15:0] lfsr_q, lfsr_d;

   // Shift in the XOR of the tap bits every cycle.
   always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // LFSR register, reseeded on reset.
   always_ff @(posedge clk) begin
      if (!resetn) lfsr_q <= 16'hACE1;
      else         lfsr_q <= lfsr_d;
   end

   assign stall = (lfsr_q[1:0] == 2'b00);
endmodule

// File: rtl/cbus_ram_responder.sv
// Word-addressed RAM responder for the cbus burst protocol.
// Optional macro CBUS_RAM_RANDOM_STALL_EN inserts pseudo-random wait cycles.
// The array is not reset; its power-up image is provided by the environment.
module cbus_ram_responder
   import cbus_ram_responder_pkg::*;
#(
   parameter int    WORDS     = 4096,
   parameter string INIT_FILE = ""
) (
   input  logic       clk,
   input  logic       resetn,
   input  cbus_req_t  creq,
   output cbus_resp_t cresp
);
   localparam int IW = $clog2(WORDS);

   cbus_state_e state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   mlen_t         cnt_q, cnt_d;
   logic [31:0]   mem_q [WORDS];
   logic          stall, beat, last_beat;

   // Address bits outside the index and the size field carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{creq.size, creq.addr[31:IW+2], creq.addr[1:0]};

`ifdef CBUS_RAM_RANDOM_STALL_EN
   cbus_stall_lfsr u_stall (.clk(clk), .resetn(resetn), .stall(stall));
`else
   assign stall = 1'b0;
`endif

   // Next-state, burst bookkeeping and response; a beat is never offered in reset.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      beat      = 1'b0;
      last_beat = 1'b0;
      cresp     = '0;
      case (state_q)
         IDLE: begin
            if (creq.valid && !stall) begin
               idx_d   = creq.addr[IW+1:2];
               cnt_d   = creq.len;
               state_d = creq.is_write ? WRITE : READ;
            end
         end
         READ, WRITE: begin
            beat      = resetn && !stall;
            last_beat = (cnt_q == '0);
            if (beat) begin
               idx_d       = idx_q + 1'b1;
               cnt_d       = last_beat ? '0 : cnt_q - 1'b1;
               cresp.ready = 1'b1;
               cresp.last  = last_beat;
               if (state_q == READ) cresp.data = mem_q[idx_q];
               if (last_beat) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM and burst counters.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // Byte-masked RAM write on each accepted write beat.
   always_ff @(posedge clk) begin
      if (beat && state_q == WRITE) begin
         for (int b = 0; b < 4; b++) begin
            if (creq.strobe[b]) mem_q[idx_q][8*b +: 8] <= creq.data[8*b +: 8];
         end
      end
   end

   // Initiator must hold valid for the whole burst; the FSM finishes anyway.
   always_ff @(posedge clk) begin
      if (resetn && (state_q == READ || state_q == WRITE))
         assert (creq.valid)
         else $error("cbus_ram_responder[%s]: creq.valid dropped mid-burst", INIT_FILE);
   end
endmodule

// File: tb/tb_cbus_ram_responder.sv
// Self-checking bench for cbus_ram_responder (WORDS=16 to reach wrap/alias).
module tb_cbus_ram_responder;
   import cbus_ram_responder_pkg::*;

   localparam int WORDS = 16;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   cbus_req_t  creq;
   cbus_resp_t cresp;

   int checks = 0;
   int failures = 0;

   logic [31:0] model [WORDS];
   logic [31:0] wdata [16];
   logic [3:0]  wstrb [16];
   logic [31:0] rd_q [$];
   int          txn_cycles;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
      string       name;
   } vec_t;
   vec_t vecs [9];

   cbus_ram_responder #(.WORDS(WORDS), .INIT_FILE("")) dut (
      .clk(clk), .resetn(resetn), .creq(creq), .cresp(cresp)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_at(input int i);
      if (i < rd_q.size()) return rd_q[i];
      return 32'hxxxx_xxxx;
   endfunction

   // One transaction; wdata/wstrb supply per-beat write data. abort_after>0
   // pulls resetn low once that many beats have been accepted.
   task automatic txn(input bit wr, input logic [31:0] addr, input mlen_t len, input int abort_after);
      int beat = 0;
      int cyc = 0;
      int idx;
      bit done = 0;
      rd_q.delete();
      @(posedge clk); #1;
      creq.valid = 1'b1; creq.is_write = wr; creq.size = MSIZE4;
      creq.addr = addr; creq.len = len; creq.data = wdata[0]; creq.strobe = wstrb[0];
      while (!done) begin
         @(negedge clk); cyc++;
         if (cyc > 400) begin
            checks++; failures++;
            $display("FAIL txn_timeout: got %0d beats expected %0d", beat, len + 1);
            break;
         end
         if (cresp.ready) begin
            idx = int'(((addr >> 2) + beat) % WORDS);
            chk("last_flag", {31'd0, cresp.last}, {31'd0, beat == int'(len)});
            if (wr) begin
               chk("wr_beat_data_zero", cresp.data, 32'h0);
               for (int b = 0; b < 4; b++)
                  if (wstrb[beat][b]) model[idx][8*b +: 8] = wdata[beat][8*b +: 8];
            end else begin
               chk("rd_beat_data", cresp.data, model[idx]);
               rd_q.push_back(cresp.data);
            end
            beat++;
            if (beat == int'(len) + 1) done = 1;
            else begin
               @(posedge clk); #1;
               if (beat == abort_after) begin
                  resetn = 1'b0; creq.valid = 1'b0;
                  @(negedge clk);
                  chk("rst_ready", {31'd0, cresp.ready}, 32'd0);
                  chk("rst_last", {31'd0, cresp.last}, 32'd0);
                  @(posedge clk); #1;
                  @(negedge clk);
                  chk("rst_idle_ready", {31'd0, cresp.ready}, 32'd0);
                  chk("rst_idle_data", cresp.data, 32'h0);
                  @(posedge clk); #1;
                  resetn = 1'b1;
                  return;
               end
               creq.data = wdata[beat]; creq.strobe = wstrb[beat];
            end
         end else begin
            chk("wait_last", {31'd0, cresp.last}, 32'd0);
            chk("wait_data", cresp.data, 32'h0);
         end
      end
      @(posedge clk); #1;
      creq.valid = 1'b0;
      @(negedge clk);
      chk("done_ready", {31'd0, cresp.ready}, 32'd0);
      txn_cycles = cyc;
`ifndef CBUS_RAM_RANDOM_STALL_EN
      chk("latency_cycles", cyc, int'(len) + 2);
`endif
   endtask

   initial begin
      mlen_t lens [5];
      lens = '{MLEN1, MLEN2, MLEN4, MLEN8, MLEN16};
      vecs[0] = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF,    32'h0,        "wr_word4"};
      vecs[1] = '{1'b0, 32'h10,       32'h0,        4'h0,    32'hDEADBEEF, "single_read"};
      vecs[2] = '{1'b1, 32'h08,       32'h11223344, 4'hF,    32'h0,        "wr_word2"};
      vecs[3] = '{1'b1, 32'h08,       32'hAABBCCDD, 4'b0101, 32'h0,        "wr_strobed"};
      vecs[4] = '{1'b0, 32'h08,       32'h0,        4'h0,    32'h11BB33DD, "strobe_merge"};
      vecs[5] = '{1'b1, 32'h0C,       32'h12345678, 4'h0,    32'h0,        "wr_nostrobe"};
      vecs[6] = '{1'b0, 32'h0C,       32'h0,        4'h0,    32'd19,       "strobe0_noop"};
      vecs[7] = '{1'b0, 32'h40,       32'h0,        4'h0,    32'd16,       "alias_0x40"};
      vecs[8] = '{1'b0, 32'h1000_0014, 32'h0,       4'h0,    32'd21,       "alias_high"};

      creq = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", {31'd0, cresp.ready}, 32'd0);
      chk("reset_last", {31'd0, cresp.last}, 32'd0);
      chk("reset_data", cresp.data, 32'h0);
      @(posedge clk); #1;
      resetn = 1'b1;

      // Preload via a 16-beat write at 0x40 (aliases to word 0): mem[i]=16+i.
      for (int i = 0; i < 16; i++) begin wdata[i] = 32'(16 + i); wstrb[i] = 4'hF; end
      txn(1'b1, 32'h40, MLEN16, -1);
      txn(1'b0, 32'h40, MLEN16, -1);
      chk("burst16_count", rd_q.size(), 16);
      for (int i = 0; i < 16; i++) chk("burst16_data", rd_at(i), 32'(16 + i));
`ifdef CBUS_RAM_RANDOM_STALL_EN
      chk("stall_cycles_gt16", {31'd0, txn_cycles > 17}, 32'd1);
`endif

      for (int v = 0; v < 9; v++) begin
         wdata[0] = vecs[v].data; wstrb[0] = vecs[v].strb;
         txn(vecs[v].wr, vecs[v].addr, MLEN1, -1);
         if (!vecs[v].wr) chk(vecs[v].name, rd_at(0), vecs[v].exp);
      end

      // Index wrap: 0x38 -> words 14,15,0,1.
      txn(1'b0, 32'h38, MLEN4, -1);
      chk("wrap_b0", rd_at(0), 32'd30);
      chk("wrap_b1", rd_at(1), 32'd31);
      chk("wrap_b2", rd_at(2), 32'd16);
      chk("wrap_b3", rd_at(3), 32'd17);

      // Reset after 3 beats of an 8-beat write to words 8..15.
      for (int i = 0; i < 8; i++) begin wdata[i] = 32'hC0DE_0000 + 32'(i); wstrb[i] = 4'hF; end
      txn(1'b1, 32'h20, MLEN8, 3);
      txn(1'b0, 32'h20, MLEN8, -1);
      for (int i = 0; i < 8; i++)
         chk("abort_readback", rd_at(i), (i < 3) ? 32'hC0DE_0000 + 32'(i) : 32'(24 + i));

      // Random traffic against the array model.
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 16; i++) begin wdata[i] = $urandom; wstrb[i] = 4'($urandom); end
         txn(1'($urandom_range(0, 1)), $urandom, lens[$urandom_range(0, 4)], -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
